// File: rtl/exa_vc_pkt_tx.sv
// Per-VC ExaNet link transmitter: strict-priority / round-robin arbitration over credited channels.
// Latency: header valid one cycle after an eligible request; payload is a combinational pass-through.
// Backpressure: each valid and its data are held until the matching ready; no credit means no grant.
module exa_vc_pkt_tx #(
  parameter int vc_num       = 2,
  parameter int prio_num     = 2,
  parameter int DATA_WIDTH   = 128,
  parameter int LEN_WIDTH    = 8,
  parameter int CREDIT_INIT  = 4,
  parameter int CREDIT_WIDTH = 4,
  localparam int NCH  = prio_num * vc_num,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                                  ACLK,
  input  logic                                  ARESETN,
  input  logic [NCH-1:0]                        i_req_valid,
  input  logic [NCH-1:0][DATA_WIDTH-1:0]        i_req_header,
  input  logic [NCH-1:0][LEN_WIDTH-1:0]         i_req_len,
  output logic [NCH-1:0]                        o_req_ack,
  input  logic [DATA_WIDTH-1:0]                 i_pld_data,
  input  logic                                  i_pld_valid,
  output logic                                  o_pld_ready,
  output logic [CH_W-1:0]                       o_pld_ch,
  output logic [DATA_WIDTH-1:0]                 o_tx_data,
  output logic                                  o_tx_header_valid,
  output logic                                  o_tx_payload_valid,
  output logic                                  o_tx_footer_valid,
  input  logic                                  i_tx_header_ready,
  input  logic                                  i_tx_payload_ready,
  input  logic                                  i_tx_footer_ready,
  output logic [CH_W-1:0]                       o_tx_ch,
  input  logic [NCH-1:0]                        i_credit_return,
  output logic [NCH-1:0][CREDIT_WIDTH-1:0]      o_credits,
  output logic                                  o_credit_err,
  output logic                                  o_busy
);

  localparam int VC_W = (vc_num > 1) ? $clog2(vc_num) : 1;
  localparam int PR_W = (prio_num > 1) ? $clog2(prio_num) : 1;
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = '1;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, FOOTER} state_t;

  state_t                              state_q, state_d;
  logic [CH_W-1:0]                     ch_q;
  logic [DATA_WIDTH-1:0]               hdr_q;
  logic [LEN_WIDTH-1:0]                len_q;
  logic [LEN_WIDTH-1:0]                beat_q;
  logic [NCH-1:0][CREDIT_WIDTH-1:0]    credit_q;
  logic [NCH-1:0][15:0]                seq_q;
  logic [prio_num-1:0][VC_W-1:0]       rr_q;
  logic                                credit_err_q;

  logic [NCH-1:0]                      elig;
  logic                                gnt_vld;
  logic [CH_W-1:0]                     gnt_ch;
  logic [PR_W-1:0]                     gnt_p;
  logic [VC_W-1:0]                     gnt_v;
  logic                                hdr_hs, pld_hs, ftr_hs;
  logic [DATA_WIDTH-1:0]               ftr_word;

  // A channel may compete only when it requests and still holds a credit.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      elig[c] = i_req_valid[c] && (credit_q[c] != '0);
    end
  end

  // Highest priority class wins; inside it, round-robin from that class's pointer.
  always_comb begin
    int v;
    int c;
    v       = 0;
    c       = 0;
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    gnt_p   = '0;
    gnt_v   = '0;
    for (int p = prio_num - 1; p >= 0; p--) begin
      for (int k = 0; k < vc_num; k++) begin
        v = (int'(rr_q[p]) + k) % vc_num;
        c = p * vc_num + v;
        if (!gnt_vld && elig[c]) begin
          gnt_vld = 1'b1;
          gnt_ch  = CH_W'(c);
          gnt_p   = PR_W'(p);
          gnt_v   = VC_W'(v);
        end
      end
    end
  end

  assign hdr_hs = (state_q == HEADER) && i_tx_header_ready;
  assign pld_hs = (state_q == PAYLOAD) && i_pld_valid && i_tx_payload_ready;
  assign ftr_hs = (state_q == FOOTER) && i_tx_footer_ready;

  // Footer word: length, channel and per-channel sequence number, zero elsewhere.
  always_comb begin
    ftr_word                  = '0;
    ftr_word[15:0]            = seq_q[ch_q];
    ftr_word[23:16]           = 8'(ch_q);
    ftr_word[24 +: LEN_WIDTH] = len_q;
  end

  // Next-state and link-side outputs; the payload phase is a straight pass-through.
  always_comb begin
    state_d            = state_q;
    o_tx_data          = '0;
    o_tx_header_valid  = 1'b0;
    o_tx_payload_valid = 1'b0;
    o_tx_footer_valid  = 1'b0;
    o_pld_ready        = 1'b0;
    o_req_ack          = '0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) state_d = HEADER;
      end
      HEADER: begin
        o_tx_data         = hdr_q;
        o_tx_header_valid = 1'b1;
        if (i_tx_header_ready) begin
          o_req_ack[ch_q] = 1'b1;
          state_d         = (len_q != '0) ? PAYLOAD : FOOTER;
        end
      end
      PAYLOAD: begin
        o_tx_data          = i_pld_data;
        o_tx_payload_valid = i_pld_valid;
        o_pld_ready        = i_tx_payload_ready;
        if (pld_hs && (beat_q == LEN_WIDTH'(1))) state_d = FOOTER;
      end
      FOOTER: begin
        o_tx_data         = ftr_word;
        o_tx_footer_valid = 1'b1;
        if (i_tx_footer_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus the packet latch taken at grant time.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      ch_q    <= '0;
      hdr_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && gnt_vld) begin
        ch_q  <= gnt_ch;
        hdr_q <= i_req_header[gnt_ch];
        len_q <= i_req_len[gnt_ch];
        if (int'(gnt_v) == vc_num - 1) rr_q[gnt_p] <= '0;
        else                           rr_q[gnt_p] <= gnt_v + 1'b1;
      end
      if (hdr_hs)      beat_q <= len_q;
      else if (pld_hs) beat_q <= beat_q - 1'b1;
    end
  end

  // Per-channel credits and sequence numbers; a return at the ceiling is flagged, never lost silently.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int c = 0; c < NCH; c++) begin
        credit_q[c] <= CREDIT_WIDTH'(CREDIT_INIT);
        seq_q[c]    <= '0;
      end
      credit_err_q <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (hdr_hs && ch_q == CH_W'(c) && !i_credit_return[c]) begin
          credit_q[c] <= credit_q[c] - 1'b1;
        end else if (!(hdr_hs && ch_q == CH_W'(c)) && i_credit_return[c]) begin
          if (credit_q[c] == CREDIT_MAX) credit_err_q <= 1'b1;
          else                           credit_q[c]  <= credit_q[c] + 1'b1;
        end
      end
      if (ftr_hs) seq_q[ch_q] <= seq_q[ch_q] + 16'd1;
    end
  end

  assign o_tx_ch      = ch_q;
  assign o_pld_ch     = ch_q;
  assign o_credits    = credit_q;
  assign o_credit_err = credit_err_q;
  assign o_busy       = (state_q != IDLE);

endmodule
